// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative restoring divider for the EX stage.
// Produces one quotient bit per clock for DIV/DIVU and packs the result as
// {remainder, quotient} for the EX/MEM register (HI/LO). While a division is
// outstanding it holds the pipeline through the combinational stall output.
module ex_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign,
  input  logic               flush,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               stall,
  output logic [2*WIDTH-1:0] ex_div
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvsr_q, dvsr_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   exdiv_q, exdiv_d;

  // One restoring step: shift {rem, quo} left and trial-subtract the divisor.
  logic [WIDTH:0]       shifted;
  logic                 fits;
  logic [WIDTH-1:0]     rem_nxt;
  logic [WIDTH-1:0]     quo_nxt;

  // Two's-complement negation of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Single restoring iteration; the remainder only ever holds values below
  // the divisor, so the subtraction result always fits back into WIDTH bits.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvsr_q});
    rem_nxt = fits ? (shifted[WIDTH-1:0] - dvsr_q) : shifted[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], fits};
  end

  // Next-state and datapath control for IDLE -> CALC -> DONE.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    exdiv_d = exdiv_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          if (divisor == '0) begin
            exdiv_d = {dividend, {WIDTH{1'b1}}};
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            quo_d   = (sign && dividend[WIDTH-1]) ? negate(dividend) : dividend;
            dvsr_d  = (sign && divisor[WIDTH-1])  ? negate(divisor)  : divisor;
            qneg_d  = sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_d  = sign && dividend[WIDTH-1];
            rem_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (flush) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            exdiv_d = {rneg_q ? negate(rem_nxt) : rem_nxt,
                       qneg_q ? negate(quo_nxt) : quo_nxt};
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      exdiv_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      exdiv_q <= exdiv_d;
    end
  end

  // The hold request ends during the done cycle so EX/MEM captures ex_div,
  // and a flush releases the pipeline in the same cycle.
  assign stall  = ((state_q == IDLE) && start && !flush) ||
                  ((state_q == CALC) && !flush);
  assign busy   = busy_q;
  assign done   = done_q;
  assign ex_div = exdiv_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: directed self-checking bench for ex_div_unit.
module tb_ex_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign;
  logic        flush;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        stall;
  logic [63:0] ex_div;

  int assertCount = 0;
  int failCount   = 0;

  ex_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sign     (sign),
    .flush    (flush),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .stall    (stall),
    .ex_div   (ex_div)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Issues one division for a single cycle, then follows it to completion.
  task automatic applyStimulus(input string tag, input logic s,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] expected, input int expEdges);
    int   edges;
    logic sawBusy;
    @(negedge clk);
    start = 1'b1; sign = s; dividend = a; divisor = b;
    #1 checkOutput({tag, "_stall_req"}, 64'(stall), 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0; dividend = 32'h0; divisor = 32'h0;
    edges   = 1;
    sawBusy = busy;
    while (!done && edges < 100) begin
      if (busy) checkOutput({tag, "_stall_calc"}, 64'(stall), 64'd1);
      @(posedge clk);
      #1;
      edges++;
      sawBusy |= busy;
    end
    checkOutput({tag, "_latency"}, 64'(edges), 64'(expEdges));
    checkOutput({tag, "_result"}, ex_div, expected);
    checkOutput({tag, "_stall_done"}, 64'(stall), 64'd0);
    checkOutput({tag, "_busy_seen"}, 64'(sawBusy), (expEdges > 1) ? 64'd1 : 64'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
    checkOutput({tag, "_hold"}, ex_div, expected);
  endtask

  // Watches a number of cycles for an unexpected done pulse.
  task automatic expectNoDone(input string tag, input int cycles);
    logic sawDone;
    sawDone = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      sawDone |= done;
    end
    checkOutput(tag, 64'(sawDone), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sign = 1'b0; flush = 1'b0;
    dividend = 32'h0; divisor = 32'h0;

    // Start asserted while reset is held: nothing may happen.
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; dividend = 32'h0000_0005; divisor = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_start_exdiv", ex_div, 64'h0);
    checkOutput("rst_start_done", 64'(done), 64'd0);
    start = 1'b0;
    rst   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_exdiv", ex_div, 64'h0);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("idle_done", 64'(done), 64'd0);
    checkOutput("idle_stall", 64'(stall), 64'd0);

    // Directed divisions with hand-computed results.
    applyStimulus("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
    applyStimulus("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    applyStimulus("div_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33);
    applyStimulus("divu_big_2", 1'b0, 32'hFFFF_FFF9, 32'h2, {32'h1, 32'h7FFF_FFFC}, 33);
    applyStimulus("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'hE}, 33);
    applyStimulus("div_by_zero", 1'b0, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'hFFFF_FFFF}, 1);
    applyStimulus("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
    applyStimulus("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'h1, {32'h0, 32'hFFFF_FFFF}, 33);

    // Flush at iteration 10: back to IDLE, no done, result untouched.
    @(negedge clk);
    start = 1'b1; sign = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    #1 checkOutput("flush_stall_drop", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_busy", 64'(busy), 64'd0);
    checkOutput("flush_stall_idle", 64'(stall), 64'd0);
    expectNoDone("flush_no_done", 40);
    checkOutput("flush_exdiv_kept", ex_div, {32'h0, 32'hFFFF_FFFF});

    // Flush together with start in IDLE: the start is ignored.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; dividend = 32'd9; divisor = 32'd3;
    #1 checkOutput("flush_start_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    checkOutput("flush_start_busy", 64'(busy), 64'd0);
    expectNoDone("flush_start_no_done", 5);

    // Reset at iteration 5 discards the division and clears the result.
    @(negedge clk);
    start = 1'b1; sign = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_mid_exdiv", ex_div, 64'h0);
    checkOutput("rst_mid_busy", 64'(busy), 64'd0);
    expectNoDone("rst_mid_no_done", 40);

    // Start while busy is ignored; the original operands finish normally.
    fork
      begin
        repeat (6) @(posedge clk);
        #2;
        start = 1'b1; sign = 1'b1; dividend = 32'd50; divisor = 32'd5;
        repeat (3) @(posedge clk);
        #2;
        start = 1'b0;
      end
      applyStimulus("busy_restart", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
    join
    checkOutput("busy_restart_idle", 64'(busy), 64'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
